// File: rtl/acc_stream_pkg.sv
// acc_stream shared types and constants.
// Holds the FSM encoding and default counter widths.
`timescale 1ns/1ps
package acc_stream_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DATA_W    = 32;
    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 16;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder used as the accumulator datapath.
// Purely combinational; carry-in exposed for reuse.
`timescale 1ns/1ps
module adder32
    import acc_stream_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < DATA_W; i++) begin : g_bit
            assign sum[i]  = a[i] ^ b[i] ^ c[i];
            assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[DATA_W];

endmodule

// File: rtl/acc_stream.sv
// Streaming packet accumulator with carry and length counters.
// Optional sticky saturation under ACC_STREAM_SAT_EN.
`timescale 1ns/1ps
module acc_stream
    import acc_stream_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_carry_cnt,
    output logic [LEN_W-1:0]  out_len
);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_n;
    logic [DATA_W-1:0] add_sum;
    logic              add_co;
    logic              hs;
    logic              rel;

    assign hs  = in_valid && in_ready;
    assign rel = (state == DONE) && out_ready;

    adder32 u_add (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_co)
    );

    assign cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(add_co);
    assign len_n = (len == '1) ? len : len + LEN_W'(1);

`ifdef ACC_STREAM_SAT_EN
    logic sat;
    logic sat_n;

    // once any carry is seen the packet total pins at all-ones
    assign sat_n = sat | add_co;
    assign acc_n = sat_n ? '1 : add_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (clr || rel) begin
            sat <= 1'b0;
        end else if (hs) begin
            sat <= sat_n;
        end
    end
`else
    assign acc_n = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (hs && in_last) state_n = DONE;
            DONE:  if (out_ready)     state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
        if (clr) state_n = ACCUM;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: in_ready  = 1'b1;
            DONE:  out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // clr wins over a same-cycle beat or result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            len <= '0;
        end else if (clr || rel) begin
            acc <= '0;
            cnt <= '0;
            len <= '0;
        end else if (hs) begin
            acc <= acc_n;
            cnt <= cnt_n;
            len <= len_n;
        end
    end

    assign out_sum       = acc;
    assign out_carry_cnt = cnt;
    assign out_len       = len;

endmodule

// File: tb/tb_acc_stream.sv
// Scoreboard bench for acc_stream: default widths plus a narrow
// instance (CNT_W=2, LEN_W=3) driven by the same stream.
`timescale 1ns/1ps
module tb_acc_stream;

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  c8;
        logic [15:0] l16;
        logic [1:0]  c2;
        logic [2:0]  l3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] out_sum;
    logic [7:0]  out_carry_cnt;
    logic [15:0] out_len;
    logic        in_ready2, out_valid2;
    logic [31:0] out_sum2;
    logic [1:0]  out_carry_cnt2;
    logic [2:0]  out_len2;

    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_ready = 0;
    exp_t q[$];

    logic [31:0] m_sum;
    bit          m_sat;
    int          m_carries;
    int          m_len;

    acc_stream dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry_cnt(out_carry_cnt),
        .out_len(out_len)
    );

    acc_stream #(.CNT_W(2), .LEN_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_carry_cnt(out_carry_cnt2),
        .out_len(out_len2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom % 3) != 0;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int smin(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_clear();
        m_sum = '0;
        m_sat = 0;
        m_carries = 0;
        m_len = 0;
    endtask

    // packet total as plain modular arithmetic; counts kept unbounded
    task automatic model_accept(input logic [31:0] d, input logic l);
        exp_t        e;
        logic [32:0] t;
        t = {1'b0, m_sum} + {1'b0, d};
        m_sum = t[31:0];
        m_carries += int'(t[32]);
        m_len++;
`ifdef ACC_STREAM_SAT_EN
        if (t[32]) m_sat = 1;
        if (m_sat) m_sum = '1;
`endif
        if (l) begin
            e.sum = m_sum;
            e.c8  = 8'(smin(m_carries, 255));
            e.l16 = 16'(smin(m_len, 65535));
            e.c2  = 2'(smin(m_carries, 3));
            e.l3  = 3'(smin(m_len, 7));
            q.push_back(e);
            model_clear();
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        logic rdy;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("beat_timeout", 0, 1);
        else model_accept(d, l);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom % 2);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || !in_ready) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", t < 300, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("sum",   out_sum,        q[0].sum);
                chk("cnt",   out_carry_cnt,  q[0].c8);
                chk("len",   out_len,        q[0].l16);
                chk("sum_n", out_sum2,       q[0].sum);
                chk("cnt_n", out_carry_cnt2, q[0].c2);
                chk("len_n", out_len2,       q[0].l3);
                chk("in_ready_done", in_ready, 0);
                if (out_ready && !clr) void'(q.pop_front());
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,      1);
        chk("rst_out_valid", out_valid,     0);
        chk("rst_sum",       out_sum,       0);
        chk("rst_cnt",       out_carry_cnt, 0);
        chk("rst_len",       out_len,       0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic packet and handshake latency
        out_ready = 1'b1;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b1);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_in_ready",  in_ready,  0);
        chk("lat_sum",       out_sum,   6);
        @(posedge clk);
        #1;
        chk("bubble_out_valid", out_valid, 0);
        chk("bubble_in_ready",  in_ready,  1);

        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'h0000_0002, 1'b1);
        drain();

        // held result must stay stable under back-pressure
        out_ready = 1'b0;
        beat(32'hDEAD_BEEF, 1'b1);
        repeat (5) begin
            chk("hold_valid",    out_valid, 1);
            chk("hold_in_ready", in_ready,  0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", out_valid, 0);
        chk("release_sum",   out_sum,   0);
        beat(32'd1, 1'b1);
        drain();

        // clr drops partial packet and the same-cycle beat
        beat(32'd5, 1'b0);
        beat(32'd7, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd9;
        in_last  = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("clr_valid", out_valid, 0);
        chk("clr_sum",   out_sum,   0);
        chk("clr_len",   out_len,   0);
        beat(32'd4, 1'b1);
        drain();

        // clr discards a pending result even with out_ready high
        out_ready = 1'b0;
        beat(32'd11, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        void'(q.pop_front());
        chk("clr_done_valid", out_valid, 0);
        chk("clr_done_sum",   out_sum,   0);

        // asynchronous reset mid-packet
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum",      out_sum,       0);
        chk("arst_len",      out_len,       0);
        chk("arst_cnt",      out_carry_cnt, 0);
        chk("arst_in_ready", in_ready,      1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(32'd3, 1'b1);
        drain();

        // carry and length saturation on the narrow instance
        for (int i = 0; i < 9; i++) beat(32'h8000_0000, i == 8);
        for (int i = 0; i < 6; i++) beat(32'hFFFF_FFFF, i == 5);
        drain();

        // random packets with random gaps and back-pressure
        rand_ready = 1;
        for (int p = 0; p < 25; p++) begin
            int n;
            n = 1 + int'($urandom % 9);
            for (int b = 0; b < n; b++) begin
                logic [31:0] d;
                d = ($urandom % 3 == 0) ? 32'hFFFF_FF00 | ($urandom % 256) : $urandom;
                beat(d, b == n - 1);
                repeat ($urandom % 3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
